// File: rtl/fxp_alu_pipe.sv
// Two-stage fixed-point ALU: S1 registers operands, S2 registers the result.
// MAC accumulates across consecutive MAC ops; any other op ends the sequence.
module fxp_alu_pipe #(
  parameter int DATA_W = 32'sd12,
  parameter int FRAC_W = 32'sd5,
  parameter int ACC_W  = 32'sd24,
  parameter bit SAT_EN = 1'b1
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_valid,
  output logic                     o_ready,
  input  logic signed [DATA_W-1:0] i_data_a,
  input  logic signed [DATA_W-1:0] i_data_b,
  input  logic [2:0]               i_inst,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic signed [DATA_W-1:0] o_data,
  output logic                     o_overflow
);

  typedef enum logic [2:0] {
    OP_ADD    = 3'd0,
    OP_SUB    = 3'd1,
    OP_MUL    = 3'd2,
    OP_MAC    = 3'd3,
    OP_XNOR   = 3'd4,
    OP_RELU   = 3'd5,
    OP_MEAN   = 3'd6,
    OP_ABSMAX = 3'd7
  } op_e;

  localparam logic signed [ACC_W-1:0]    MAX_C = ACC_W'({1'b0, {(DATA_W-1){1'b1}}});
  localparam logic signed [ACC_W-1:0]    MIN_C = ~MAX_C;
  localparam logic signed [2*DATA_W-1:0] RND_C = (2*DATA_W)'(1'b1) << (FRAC_W-1);

  // Returns {out_of_range, result}; saturates by sign or keeps the low bits.
  function automatic logic [DATA_W:0] range_fit(input logic signed [ACC_W-1:0] v);
    logic              ovf;
    logic [DATA_W-1:0] d;
    ovf = (v > MAX_C) || (v < MIN_C);
    if (ovf && SAT_EN) begin
      d = v[ACC_W-1] ? MIN_C[DATA_W-1:0] : MAX_C[DATA_W-1:0];
    end else begin
      d = v[DATA_W-1:0];
    end
    return {ovf, d};
  endfunction

  logic                     s1_valid_r, s2_valid_r, o_ovf_r, sticky_r;
  logic signed [DATA_W-1:0] s1_a_r, s1_b_r, o_data_r;
  op_e                      s1_op_r;
  logic signed [ACC_W-1:0]  acc_r;

  logic                       s2_adv_s, s1_xfer_s, accept_s, chk_s, res_ovf_s;
  logic signed [ACC_W-1:0]    a_x_s, b_x_s, sum_s, dif_s, abs_a_s, abs_b_s, mean_s, acc_next_s, wide_s;
  logic signed [2*DATA_W-1:0] prod_s, rnd_s;
  logic signed [DATA_W-1:0]   raw_s, res_data_s;
  logic [DATA_W:0]            fit_s;

  assign o_ready    = !s1_valid_r || !s2_valid_r || i_ready;
  assign o_valid    = s2_valid_r;
  assign o_data     = o_data_r;
  assign o_overflow = o_ovf_r;

  // Handshake decode and S1 datapath for the result presented to S2.
  always_comb begin
    s2_adv_s   = !s2_valid_r || i_ready;
    s1_xfer_s  = s1_valid_r && s2_adv_s;
    accept_s   = i_valid && o_ready;
    a_x_s      = ACC_W'(s1_a_r);
    b_x_s      = ACC_W'(s1_b_r);
    sum_s      = a_x_s + b_x_s;
    dif_s      = a_x_s - b_x_s;
    mean_s     = sum_s >>> 1'b1;
    abs_a_s    = a_x_s[ACC_W-1] ? -a_x_s : a_x_s;
    abs_b_s    = b_x_s[ACC_W-1] ? -b_x_s : b_x_s;
    prod_s     = (2*DATA_W)'(s1_a_r) * (2*DATA_W)'(s1_b_r);
    rnd_s      = (prod_s + RND_C) >>> FRAC_W;
    acc_next_s = acc_r + ACC_W'(rnd_s);
    wide_s     = {ACC_W{1'b0}};
    raw_s      = {DATA_W{1'b0}};
    chk_s      = 1'b1;
    case (s1_op_r)
      OP_ADD:    wide_s = sum_s;
      OP_SUB:    wide_s = dif_s;
      OP_MUL:    wide_s = ACC_W'(rnd_s);
      OP_MAC:    wide_s = acc_next_s;
      OP_ABSMAX: wide_s = (abs_a_s > abs_b_s) ? abs_a_s : abs_b_s;
      OP_XNOR: begin
        chk_s = 1'b0;
        raw_s = ~(s1_a_r ^ s1_b_r);
      end
      OP_RELU: begin
        chk_s = 1'b0;
        raw_s = s1_a_r[DATA_W-1] ? {DATA_W{1'b0}} : s1_a_r;
      end
      OP_MEAN: begin
        chk_s = 1'b0;
        raw_s = mean_s[DATA_W-1:0];
      end
      default: begin
        chk_s = 1'b0;
        raw_s = {DATA_W{1'b0}};
      end
    endcase
    fit_s = range_fit(wide_s);
    if (chk_s) begin
      res_data_s = fit_s[DATA_W-1:0];
      res_ovf_s  = fit_s[DATA_W] || ((s1_op_r == OP_MAC) && sticky_r);
    end else begin
      res_data_s = raw_s;
      res_ovf_s  = 1'b0;
    end
  end

  // S1 operand register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_valid_r <= 1'b0;
      s1_a_r     <= {DATA_W{1'b0}};
      s1_b_r     <= {DATA_W{1'b0}};
      s1_op_r    <= OP_ADD;
    end else if (accept_s) begin
      s1_valid_r <= 1'b1;
      s1_a_r     <= i_data_a;
      s1_b_r     <= i_data_b;
      s1_op_r    <= op_e'(i_inst);
    end else if (s1_xfer_s) begin
      s1_valid_r <= 1'b0;
    end
  end

  // S2 result register; holds while the consumer stalls.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s2_valid_r <= 1'b0;
      o_data_r   <= {DATA_W{1'b0}};
      o_ovf_r    <= 1'b0;
    end else if (s2_adv_s) begin
      s2_valid_r <= s1_valid_r;
      if (s1_valid_r) begin
        o_data_r <= res_data_s;
        o_ovf_r  <= res_ovf_s;
      end
    end
  end

  // MAC accumulator and sticky flag advance only when an op moves into S2.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      acc_r    <= {ACC_W{1'b0}};
      sticky_r <= 1'b0;
    end else if (s1_xfer_s) begin
      if (s1_op_r == OP_MAC) begin
        acc_r    <= acc_next_s;
        sticky_r <= sticky_r || fit_s[DATA_W];
      end else begin
        acc_r    <= {ACC_W{1'b0}};
        sticky_r <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fxp_alu_pipe.sv
// Directed bench for fxp_alu_pipe: a saturating and a wrapping instance share stimulus.
module tb_fxp_alu_pipe;
  localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, MUL = 3'd2, MAC = 3'd3;
  localparam logic [2:0] XNR = 3'd4, RELU = 3'd5, MEAN = 3'd6, AMAX = 3'd7;

  logic clk = 1'b0, rst_n = 1'b0, i_valid = 1'b0, i_ready = 1'b1;
  logic signed [11:0] a = 12'sd0, b = 12'sd0;
  logic [2:0] inst = 3'd0;
  logic o_ready_s, o_valid_s, o_ovf_s, o_ready_w, o_valid_w, o_ovf_w;
  logic signed [11:0] o_data_s, o_data_w;
  int n_vec = 0, n_bad = 0;

  typedef struct {
    string name; logic [2:0] op; int a; int b;
    logic [11:0] ds; logic os; logic [11:0] dw; logic ow;
  } vec_t;
  vec_t tbl[$];

  fxp_alu_pipe #(.DATA_W(12), .FRAC_W(5), .ACC_W(24), .SAT_EN(1'b1)) dut_s (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready_s),
    .i_data_a(a), .i_data_b(b), .i_inst(inst), .o_valid(o_valid_s),
    .i_ready(i_ready), .o_data(o_data_s), .o_overflow(o_ovf_s));

  fxp_alu_pipe #(.DATA_W(12), .FRAC_W(5), .ACC_W(24), .SAT_EN(1'b0)) dut_w (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready_w),
    .i_data_a(a), .i_data_b(b), .i_inst(inst), .o_valid(o_valid_w),
    .i_ready(i_ready), .o_data(o_data_w), .o_overflow(o_ovf_w));

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", n, act, exp);
    end
  endtask

  task automatic add(input string n, input logic [2:0] op, input int va, input int vb,
                     input logic [11:0] ds, input logic os, input logic [11:0] dw, input logic ow);
    vec_t v;
    v.name = n; v.op = op; v.a = va; v.b = vb;
    v.ds = ds; v.os = os; v.dw = dw; v.ow = ow;
    tbl.push_back(v);
  endtask

  // One op into an idle pipe: no result one cycle after accept, result the cycle after.
  task automatic apply(input vec_t v);
    @(negedge clk);
    i_ready = 1'b1; i_valid = 1'b1; inst = v.op; a = 12'(v.a); b = 12'(v.b);
    #1 chk({v.name, " rdy"}, {31'd0, o_ready_s}, 32'd1);
    @(negedge clk);
    i_valid = 1'b0;
    chk({v.name, " lat"}, {30'd0, o_valid_s, o_valid_w}, 32'd0);
    @(negedge clk);
    chk({v.name, " sat"}, {18'd0, o_valid_s, o_ovf_s, o_data_s}, {18'd0, 1'b1, v.os, v.ds});
    chk({v.name, " wrap"}, {18'd0, o_valid_w, o_ovf_w, o_data_w}, {18'd0, 1'b1, v.ow, v.dw});
  endtask

  logic [2:0]  sop[4] = '{MAC, MAC, MAC, ADD};
  logic [11:0] sa[4]  = '{12'd32, 12'd32, 12'd32, 12'd3};
  logic [11:0] sb[4]  = '{12'd32, 12'd32, 12'd32, 12'd4};
  logic [12:0] sexp[4] = '{13'd32, 13'd64, 13'd96, 13'd7};

  initial begin
    add("add_max",  ADD, 2047, 1,     12'h7FF, 1'b1, 12'h800, 1'b1);
    add("sub_neg",  SUB, 5, 7,        12'hFFE, 1'b0, 12'hFFE, 1'b0);
    add("sub_min",  SUB, -2048, 1,    12'h800, 1'b1, 12'h7FF, 1'b1);
    add("mul_1x2",  MUL, 32, 64,      12'h040, 1'b0, 12'h040, 1'b0);
    add("mul_max",  MUL, 2047, 2047,  12'h7FF, 1'b1, 12'hF80, 1'b1);
    add("mul_neg",  MUL, -32, 48,     12'hFD0, 1'b0, 12'hFD0, 1'b0);
    add("mul_rnd",  MUL, 48, 1,       12'h002, 1'b0, 12'h002, 1'b0);
    add("xnor",     XNR, 240, 255,    12'hFF0, 1'b0, 12'hFF0, 1'b0);
    add("relu_neg", RELU, -5, 9,      12'h000, 1'b0, 12'h000, 1'b0);
    add("relu_pos", RELU, 100, 9,     12'h064, 1'b0, 12'h064, 1'b0);
    add("mean",     MEAN, 7, 4,       12'h005, 1'b0, 12'h005, 1'b0);
    add("mean_neg", MEAN, -3, 0,      12'hFFE, 1'b0, 12'hFFE, 1'b0);
    add("mean_max", MEAN, 2047, 2047, 12'h7FF, 1'b0, 12'h7FF, 1'b0);
    add("amax_min", AMAX, -2048, 5,   12'h7FF, 1'b1, 12'h800, 1'b1);
    add("amax",     AMAX, -300, 200,  12'h12C, 1'b0, 12'h12C, 1'b0);
    add("add_clr",  ADD, 0, 0,        12'h000, 1'b0, 12'h000, 1'b0);
    add("mac1",     MAC, 32, 32,      12'h020, 1'b0, 12'h020, 1'b0);
    add("mac2",     MAC, 32, 32,      12'h040, 1'b0, 12'h040, 1'b0);
    add("mac3",     MAC, 32, 32,      12'h060, 1'b0, 12'h060, 1'b0);
    add("add_brk",  ADD, 1, 1,        12'h002, 1'b0, 12'h002, 1'b0);
    add("mac_rst",  MAC, 32, 32,      12'h020, 1'b0, 12'h020, 1'b0);
    add("relu_brk", RELU, 0, 0,       12'h000, 1'b0, 12'h000, 1'b0);
    add("mac_big",  MAC, 2047, 2047,  12'h7FF, 1'b1, 12'hF80, 1'b1);
    add("mac_stk",  MAC, 1, 1,        12'h7FF, 1'b1, 12'hF80, 1'b1);
    add("mac_back", MAC, -2047, 2047, 12'h000, 1'b1, 12'h000, 1'b1);
    add("add_clr2", ADD, 0, 0,        12'h000, 1'b0, 12'h000, 1'b0);
    add("mac_new",  MAC, 1, 32,       12'h001, 1'b0, 12'h001, 1'b0);
    add("add_end",  ADD, 3, -3,       12'h000, 1'b0, 12'h000, 1'b0);

    // Reset state
    @(negedge clk);
    chk("reset out", {17'd0, o_ready_s, o_valid_s, o_ovf_s, o_data_s}, {17'd0, 1'b1, 1'b0, 1'b0, 12'd0});
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

    // Back-to-back MACs into a stalled consumer
    begin
      int idx = 0;
      logic [12:0] got[$];
      for (int cyc = 0; cyc < 40 && got.size() < 4; cyc++) begin
        @(negedge clk);
        i_ready = (cyc >= 5);
        i_valid = (idx < 4);
        if (idx < 4) begin
          inst = sop[idx]; a = sa[idx]; b = sb[idx];
        end
        #1;
        if (cyc == 2) chk("stall ready", {31'd0, o_ready_s}, 32'd0);
        if (cyc == 3 || cyc == 4) chk("stall hold", {19'd0, o_valid_s, o_data_s}, {19'd0, 1'b1, 12'd32});
        if (i_valid && o_ready_s) idx++;
        if (o_valid_s && i_ready) got.push_back({o_ovf_s, o_data_s});
      end
      @(negedge clk);
      i_valid = 1'b0; i_ready = 1'b1;
      chk("stall count", got.size(), 32'd4);
      for (int i = 0; i < got.size() && i < 4; i++) chk("stall order", {19'd0, got[i]}, {19'd0, sexp[i]});
    end

    // Reset with both stages holding MACs
    apply(tbl[15]);
    @(negedge clk);
    i_ready = 1'b0; i_valid = 1'b1; inst = MAC; a = 12'sd32; b = 12'sd32;
    @(negedge clk);
    @(negedge clk);
    i_valid = 1'b0;
    #1 chk("full ready", {30'd0, o_ready_s, o_valid_s}, 32'd1);
    rst_n = 1'b0;
    #1 chk("mid reset", {17'd0, o_ready_s, o_valid_s, o_ovf_s, o_data_s}, {17'd0, 1'b1, 1'b0, 1'b0, 12'd0});
    @(negedge clk);
    rst_n = 1'b1; i_ready = 1'b1;
    @(negedge clk);
    chk("post reset", {31'd0, o_valid_s}, 32'd0);
    apply(tbl[16]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/fxp_alu_pipe.md
FXP_ALU_PIPE -- requirements
Module: fxp_alu_pipe

Interface
REQ-001 SHALL have parameter DATA_W, default 12, meaning operand/result width in two's-complement bits.
REQ-002 SHALL have parameter FRAC_W, default 5, meaning fraction bits for MUL/MAC rescaling (1 <= FRAC_W < DATA_W).
REQ-003 SHALL have parameter ACC_W, default 24, meaning MAC accumulator width (ACC_W >= 2*DATA_W).
REQ-004 SHALL have parameter SAT_EN, default 1, meaning out-of-range results saturate (1) or wrap (0).
REQ-005 SHALL have ports: i_clk  in  1  clock, all state on posedge; i_rst_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have ports: i_valid  in  1  request valid; o_ready  out  1  request accepted when i_valid&&o_ready.
REQ-007 SHALL have ports: i_data_a, i_data_b  in  DATA_W  signed operands; i_inst  in  3  opcode.
REQ-008 SHALL have ports: o_valid  out  1  result valid; i_ready  in  1  result consumed when o_valid&&i_ready.
REQ-009 SHALL have ports: o_data  out  DATA_W  result; o_overflow  out  1  result out of range.

Function
REQ-010 SHALL implement opcodes: 0 ADD, 1 SUB, 2 MUL, 3 MAC, 4 XNOR, 5 RELU, 6 MEAN, 7 ABSMAX.
REQ-011 SHALL be a two-stage pipeline (S1 operand register, S2 result register); latency accept->o_valid exactly 2 cycles when unstalled; throughput 1/cycle.
REQ-012 SHALL drive o_ready = !S1_valid || !S2_valid || i_ready (combinational, no i_valid dependency).
REQ-013 SHALL hold o_valid, o_data, o_overflow stable while o_valid && !i_ready; no transaction dropped or duplicated.
REQ-014 SHALL compute ADD/SUB at DATA_W+1 bits; overflow when result outside [-2^(DATA_W-1), 2^(DATA_W-1)-1].
REQ-015 SHALL compute MUL as (a*b + 2^(FRAC_W-1)) >>> FRAC_W at 2*DATA_W bits (round half up), same range check.
REQ-016 SHALL compute MEAN as (a+b) >>> 1 at DATA_W+1 bits; o_overflow always 0.
REQ-017 SHALL compute XNOR bitwise, RELU as a<0 ? 0 : a; both o_overflow 0.
REQ-018 SHALL compute ABSMAX as max(|a|,|b|) at DATA_W+1 bits; |-2^(DATA_W-1)| flags overflow.
REQ-019 SHALL, on overflow, output 2^(DATA_W-1)-1 or -2^(DATA_W-1) by sign when SAT_EN=1, else low DATA_W bits.
REQ-020 SHALL start a MAC sequence when an accepted MAC follows reset or a non-MAC accepted op; first term uses acc=0.
REQ-021 SHALL update acc_next = acc + rounded product (REQ-015), ACC_W bits, at S1->S2 transfer; output = acc_next range-checked per REQ-019.
REQ-022 SHALL keep MAC overflow sticky: once set, every later result of the same sequence has o_overflow=1.
REQ-023 SHALL clear acc and sticky flag when a non-MAC op transfers S1->S2.
REQ-024 SHALL update acc/sticky only on actual S1->S2 transfer; stalls do not re-accumulate.
REQ-025 SHALL tie sequence tracking to accepted ops only; idle cycles (no i_valid) do not break a MAC sequence.

Reset
REQ-026 SHALL on i_rst_n=0 asynchronously clear S1/S2 valid, o_data=0, o_overflow=0, acc=0, sticky=0, sequence state = "not in MAC".
REQ-027 SHALL drive o_ready=1 during and after reset; in-flight transactions discarded, o_valid=0 on first post-reset cycle.

Verification (DATA_W=12, FRAC_W=5, i_ready=1 unless stated)
REQ-028 SHALL cover ADD 2047+1 -> SAT_EN=1: o_data=2047, o_overflow=1; SAT_EN=0: o_data=0x800, o_overflow=1; o_valid 2 cycles after accept.
REQ-029 SHALL cover MUL 32*64 (1.0*2.0) -> 64, ovf 0; MUL 2047*2047 -> 2047, ovf 1 (SAT_EN=1).
REQ-030 SHALL cover MAC 32*32 x3 -> 32, 64, 96, then ADD 1+1 -> 2, then MAC 32*32 -> 32 (sequence restarted).
REQ-031 SHALL cover MAC 2047*2047 then MAC 1*1 -> both ovf 1 (sticky); ABSMAX -2048,5 -> 2047, ovf 1.
REQ-032 SHALL cover back-to-back ops with i_ready=0 for 3 cycles -> o_ready falls after 2 accepts, o_data held, all results in order, MAC summed once each.
REQ-033 SHALL cover reset asserted mid-MAC with both stages full -> o_valid=0, next MAC 32*32 -> 32.
